// File: rtl/keypad_scanner_if.sv
// Event handshake between the keypad scanner and its consumer.
// The master side presents the head of the event FIFO. The slave side accepts it with event_ready.
interface keypad_scanner_if #(
    parameter int KEY_W = 4
) ();
    logic             event_valid;
    logic             event_ready;
    logic             event_pressed;
    logic [KEY_W-1:0] event_key;

    modport master (
        output event_valid,
        output event_pressed,
        output event_key,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_pressed,
        input  event_key,
        output event_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// Shared row-strobe key matrix scanner.
// Each key has its own scan-count debounce filter, and events are queued in a small FIFO.
module keypad_scanner #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_SCANS  = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COLS-1:0]       col_sense,
    output logic [ROWS-1:0]       row_drive,
    output logic                  overflow,
    keypad_scanner_if.master      ev
);
    localparam int NKEYS  = ROWS * COLS;
    localparam int KEY_W  = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W  = $clog2(STABLE_SCANS + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {ST_DRIVE, ST_SAMPLE} state_e;

    state_e            r_state;
    logic [SET_W-1:0]  r_settle;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ROWS-1:0]   r_row_drive;
    logic              r_overflow;

    logic [ROW_W-1:0]  w_row_next;
    logic [KEY_W-1:0]  w_key;
    logic              w_sample;
    logic              w_raw;
    logic              w_deb_sel;
    logic [CNT_W-1:0]  w_cnt_sel;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_mismatch;
    logic              w_commit_req;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_valid;

    logic              w_deb_vec [NKEYS];
    logic [CNT_W-1:0]  w_cnt_arr [NKEYS];

    assign w_row_next = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
    assign w_key      = KEY_W'(r_row) * KEY_W'(COLS) + KEY_W'(r_col);
    assign w_sample   = (r_state == ST_SAMPLE);
    assign w_raw      = col_sense[r_col];

    // Row sequencer. The settle counter resets to 0 so that the reset cycle is not counted as a drive cycle.
    // Later rows enter DRIVE with the counter already at 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_DRIVE;
            r_settle    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_row_drive <= '0;
        end else begin
            case (r_state)
                ST_DRIVE: begin
                    r_row_drive <= ROWS'(1) << r_row;
                    if (r_settle == SET_W'(SETTLE_CYCLES)) begin
                        r_state <= ST_SAMPLE;
                        r_col   <= '0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_col == COL_W'(COLS - 1)) begin
                        r_state     <= ST_DRIVE;
                        r_settle    <= SET_W'(1);
                        r_row       <= w_row_next;
                        r_row_drive <= ROWS'(1) << w_row_next;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: r_state <= ST_DRIVE;
            endcase
        end
    end

    assign row_drive = r_row_drive;

    // Filter decision for the key under the sample pointer.
    // The counter sits at STABLE_SCANS while a commit is deferred, so ">=" also covers a retry.
    assign w_deb_sel    = w_deb_vec[w_key];
    assign w_cnt_sel    = w_cnt_arr[w_key];
    assign w_cnt_inc    = {1'b0, w_cnt_sel} + 1'b1;
    assign w_mismatch   = (w_raw != w_deb_sel);
    assign w_commit_req = w_sample && w_mismatch && (w_cnt_inc >= (CNT_W + 1)'(STABLE_SCANS));
    assign w_push       = w_commit_req && !w_full;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic             r_deb;
            logic [CNT_W-1:0] r_cnt;
            logic             w_sel;

            assign w_sel = w_sample && (w_key == KEY_W'(gi));

            // Per-key debounce state. It is only updated in this key's own sample cycle.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_deb <= 1'b0;
                    r_cnt <= '0;
                end else if (w_sel) begin
                    if (!w_mismatch) begin
                        r_cnt <= '0;
                    end else if (w_push) begin
                        r_deb <= ~r_deb;
                        r_cnt <= '0;
                    end else if (w_commit_req) begin
                        r_cnt <= CNT_W'(STABLE_SCANS);
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
            end

            assign w_deb_vec[gi] = r_deb;
            assign w_cnt_arr[gi] = r_cnt;
        end
    endgenerate

    // Event FIFO. A pop in the same cycle frees the slot that a push into a full FIFO needs.
    logic [KEY_W:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic [KEY_W:0]    w_head;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && ev.event_ready;
    assign w_full  = (r_count == FCNT_W'(FIFO_DEPTH)) && !w_pop;

    // FIFO storage. The output is gated by the valid flag, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {~w_deb_sel, w_key};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow pulse, asserted in the cycle after a deferred commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_commit_req && w_full;
        end
    end

    assign w_head           = r_mem[r_rd_ptr];
    assign overflow         = r_overflow;
    assign ev.event_valid   = w_valid;
    assign ev.event_pressed = w_valid & w_head[KEY_W];
    assign ev.event_key     = w_valid ? w_head[KEY_W-1:0] : '0;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with the default parameters.
// The key matrix is modelled as a bit per key. A scan-timeline reference model predicts every output.
module tb_keypad_scanner;
    localparam int SETTLE = 16;
    localparam int ROWP   = SETTLE + 4;
    localparam int SCAN   = 4 * ROWP;
    localparam int STABLE = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] col_sense;
    logic [3:0] row_drive;
    logic       overflow;

    keypad_scanner_if #(.KEY_W(4)) ev_if ();

    keypad_scanner dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .col_sense (col_sense),
        .row_drive (row_drive),
        .overflow  (overflow),
        .ev        (ev_if)
    );

    always #5 clk = ~clk;

    bit keys [16];

    // Matrix model: a closed key connects its row line to its column line.
    always_comb begin
        col_sense = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_drive[r] && keys[r*4+c]) col_sense[c] = 1'b1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_deb [16];
    int         m_cnt [16];
    logic [4:0] mq [$];
    int         m_cyc = -1;
    bit         m_ovf = 0;

    // Observation of the DUT
    int obs_press [16];
    int obs_rel   [16];
    int obs_order [$];
    int ovf_count = 0;
    int gcyc = 0;
    int t8 = -1;
    int t10 = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 16; i++) begin
            obs_press[i] = 0;
            obs_rel[i]   = 0;
        end
        obs_order.delete();
        ovf_count = 0;
    endtask

    // One clock: advance the model through the cycle that is ending, then check every output.
    task automatic step();
        bit         pop, push, defer, raw;
        int         p, off, k;
        logic [4:0] evn;
        logic [3:0] exp_row;
        pop = 0; push = 0; defer = 0; evn = '0;
        if (reset_n && ev_if.event_valid && ev_if.event_ready) begin
            if (ev_if.event_pressed) obs_press[ev_if.event_key]++;
            else                     obs_rel[ev_if.event_key]++;
            obs_order.push_back(int'(ev_if.event_key));
        end
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                m_deb[i] = 0;
                m_cnt[i] = 0;
            end
            mq.delete();
            m_cyc = -1;
        end else begin
            pop = (mq.size() != 0) && ev_if.event_ready;
            if (m_cyc >= 0) begin
                p   = m_cyc % SCAN;
                off = p % ROWP;
                if (off >= SETTLE) begin
                    k   = (p / ROWP) * 4 + (off - SETTLE);
                    raw = keys[k];
                    if (raw == m_deb[k]) begin
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] + 1 >= STABLE) begin
                        if (mq.size() == DEPTH && !pop) begin
                            defer    = 1;
                            m_cnt[k] = STABLE;
                        end else begin
                            m_deb[k] = raw;
                            m_cnt[k] = 0;
                            push     = 1;
                            evn      = {raw, 4'(k)};
                        end
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(evn);
            m_cyc++;
        end
        m_ovf = defer;
        @(posedge clk);
        #1;
        gcyc++;
        exp_row = (m_cyc >= 0) ? 4'(1 << ((m_cyc % SCAN) / ROWP)) : 4'b0000;
        chk("row_drive", row_drive, exp_row);
        chk("event_valid", ev_if.event_valid, mq.size() != 0);
        chk("event_key", ev_if.event_key, (mq.size() != 0) ? mq[0][3:0] : 4'd0);
        chk("event_pressed", ev_if.event_pressed, (mq.size() != 0) ? mq[0][4] : 1'b0);
        chk("overflow", overflow, m_ovf);
        if (overflow === 1'b1) ovf_count++;
        if (ev_if.event_valid === 1'b1 && ev_if.event_pressed === 1'b1) begin
            if (ev_if.event_key === 4'd8 && t8 < 0) t8 = gcyc;
            if (ev_if.event_key === 4'd10 && t10 < 0) t10 = gcyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next cycle is the first cycle of a scan (row 0, start of DRIVE).
    task automatic align();
        for (int i = 0; i < SCAN + 1; i++) begin
            if (m_cyc >= 0 && (m_cyc % SCAN) == 0) break;
            step();
        end
    endtask

    initial begin
        ev_if.event_ready = 1'b1;
        for (int i = 0; i < 16; i++) keys[i] = 0;
        clear_obs();

        // Reset held for 3 cycles, then one scan and a bit to cover the row sequence
        reset_n = 1'b0;
        run(3);
        reset_n = 1'b1;
        run(100);

        // A single key is held long enough to be pressed, then released
        align();
        clear_obs();
        keys[5] = 1;
        run(4 * SCAN);
        chk("single_press_count", obs_press[5], 1);
        keys[5] = 0;
        run(4 * SCAN);
        chk("single_release_count", obs_rel[5], 1);
        run(2 * SCAN);
        chk("single_no_dup_press", obs_press[5], 1);
        chk("single_no_dup_release", obs_rel[5], 1);

        // Bounce: three closed scans followed by one open scan never commit
        clear_obs();
        for (int rep = 0; rep < 3; rep++) begin
            align();
            keys[5] = 1;
            run(3 * SCAN);
            keys[5] = 0;
            run(SCAN);
        end
        chk("bounce_no_events", obs_order.size(), 0);

        // Two keys in the same row close in the same cycle
        align();
        clear_obs();
        t8 = -1;
        t10 = -1;
        keys[8] = 1;
        keys[10] = 1;
        run(4 * SCAN);
        chk("pair_order_first", obs_order.size() > 0 ? obs_order[0] : -1, 8);
        chk("pair_order_second", obs_order.size() > 1 ? obs_order[1] : -1, 10);
        chk("pair_spacing", t10 - t8, 2);
        keys[8] = 0;
        keys[10] = 0;
        run(4 * SCAN);

        // Backpressure: five keys close while the consumer stalls
        ev_if.event_ready = 1'b0;
        align();
        clear_obs();
        for (int i = 0; i < 5; i++) keys[i] = 1;
        run(6 * SCAN);
        chk("bp_overflow_pulses", ovf_count, 3);
        chk("bp_valid_held", ev_if.event_valid, 1'b1);
        clear_obs();
        ev_if.event_ready = 1'b1;
        run(2 * SCAN);
        chk("bp_drain_count", obs_order.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("bp_drain_order", obs_order.size() > i ? obs_order[i] : -1, i);
        for (int i = 0; i < 5; i++) keys[i] = 0;
        run(5 * SCAN);

        // Reset while two events are queued and key 5 is held
        ev_if.event_ready = 1'b0;
        align();
        keys[5] = 1;
        keys[6] = 1;
        run(4 * SCAN);
        chk("mid_queued_valid", ev_if.event_valid, 1'b1);
        reset_n = 1'b0;
        step();
        chk("mid_reset_valid", ev_if.event_valid, 1'b0);
        chk("mid_reset_rows", row_drive, 4'b0000);
        reset_n = 1'b1;
        clear_obs();
        keys[6] = 0;
        ev_if.event_ready = 1'b1;
        run(5 * SCAN);
        chk("mid_repress_5", obs_press[5], 1);
        chk("mid_no_release_5", obs_rel[5], 0);
        chk("mid_no_event_6", obs_press[6] + obs_rel[6], 0);
        keys[5] = 0;
        run(4 * SCAN);

        // Random key activity and random consumer stalls
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                int kk;
                kk = int'($urandom_range(0, 15));
                keys[kk] = !keys[kk];
            end
            ev_if.event_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a ROWS×COLS key matrix: strobes one row at a time, waits for the lines to settle, samples the columns and debounces every key with a per-key scan-count filter. Emits press/release events through a small event FIFO with a valid/ready handshake. Sits between the board-level key matrix pins (already synchronised) and the input consumer, such as the UI or CPU register block. It replaces per-pin `edge_detector` instances with one shared sequencer.

## Interface
- ROWS, 4, number of driven rows
- COLS, 4, number of sensed columns
- SETTLE_CYCLES, 16, cycles a row is driven before its first column sample (≥1)
- STABLE_SCANS, 4, consecutive scans a key must disagree with its debounced state before the change commits (≥1)
- FIFO_DEPTH, 4, event FIFO entries (≥1)
- clk  in  1  single clock; everything is on its rising edge
- reset_n  in  1  synchronous, active-low reset
- col_sense  in  COLS  high = key closed on the currently driven row; already synchronised
- row_drive  out  ROWS  one-hot, high = row driven; registered
- event_valid  out  1  FIFO non-empty
- event_ready  in  1  consumer accepts the head event when `event_valid && event_ready`
- event_pressed  out  1  head event: 1 = press, 0 = release
- event_key  out  $clog2(ROWS*COLS)  head event key index = row*COLS + col
- overflow  out  1  one-cycle pulse when a commit is deferred because the FIFO is full

## Operation
- Reset (reset_n low at a clock edge) clears all state:
  - row_drive=0, event_valid=0, event_pressed=0, event_key=0, overflow=0.
  - All debounced states = released; all stability counters = 0; FIFO empty; row index = 0.
- FSM has two states: DRIVE and SAMPLE. Row index r and column index c wrap modulo ROWS and COLS.
  - DRIVE: row_drive = 1<<r for SETTLE_CYCLES cycles, then go to SAMPLE with c=0.
  - SAMPLE: row_drive stays 1<<r. One key (r,c) is evaluated per cycle, c=0..COLS-1. After c=COLS-1, r advances and the FSM returns to DRIVE.
- Per-key filter, evaluated in the key's SAMPLE cycle:
  - raw == debounced: clear the counter.
  - raw != debounced: increment the counter. When the incremented value reaches STABLE_SCANS, a commit occurs.
  - Commit: flip debounced, clear the counter, push {pressed=new state, key}.
  - The counter is only touched in its own sample cycle.
- FIFO full on commit: "full" means count==FIFO_DEPTH with no pop in the same cycle.
  - Debounced state is not flipped and the counter holds at STABLE_SCANS.
  - overflow pulses for 1 cycle.
  - The commit retries at that key's next sample cycle, provided raw still disagrees. If raw agrees by then, the counter clears and no event is produced.
  - Events are never dropped or reordered.
- Simultaneous push and pop is always allowed, including when the FIFO is full (the count is unchanged).
- Output order is FIFO order. Keys in the same row commit in ascending column order.
- Counter width is $clog2(STABLE_SCANS+1). It never exceeds STABLE_SCANS.

## Timing
- First rising edge with reset_n high: row_drive becomes 1 (row 0) and DRIVE starts.
- Row period = SETTLE_CYCLES + COLS cycles. Full scan period = ROWS*(SETTLE_CYCLES+COLS) cycles, i.e. 80 with the defaults.
- Key (r,c) is sampled in the cycle at offset r*(SETTLE_CYCLES+COLS) + SETTLE_CYCLES + c from the scan start.
- Commit latency:
  - With an empty FIFO, a commit in the cycle ending at edge t gives event_valid=1 and the fields after edge t.
  - A closed key is reported on the STABLE_SCANS-th consecutive scan that sees it closed.
- event_valid, event_pressed and event_key are stable while `event_valid && !event_ready`. They change only after a pop or a push into an empty FIFO.
- overflow is asserted in the cycle after the deferred commit's sample edge, for exactly one cycle.
- Reset mid-scan or with events queued: all outputs are zero after the reset edge. Queued events are discarded. Held keys produce no release events. Scanning restarts at row 0.

## Test plan
- **Reset and scan sequencing (defaults):** hold reset_n=0 for 3 cycles, then release → all outputs 0 during reset; row_drive=0001 for 20 cycles, then 0010, 0100, 1000, and back to 0001 at cycle 80.
- **Single key (event_ready=1):** close key 5 (row 1, col 1) and hold → exactly one event {pressed=1, key=5}, on the 4th scan that sees it; open it → one event {pressed=0, key=5} after 4 scans; no duplicates.
- **Bounce rejection:** key 5 closed for 3 consecutive scans, then open for 1 scan, repeated → no events; counter restarts each time.
- **Same-row pair:** keys 8 and 10 close on the same cycle → events key=8 then key=10, pushed 2 cycles apart, both pressed=1.
- **Backpressure:** hold event_ready=0 and close keys 0, 1, 2, 3 and 4 →
  - 4 events are queued and overflow pulses once per scan while key 4 is deferred;
  - after event_ready=1, events come out in order 0, 1, 2, 3, followed by 4 on the next scan of key 4.
- **Reset mid-operation:** with 2 events queued and key 5 held, pulse reset_n=0 for 1 cycle → event_valid=0 and row_drive=0 after the edge; no release event for key 5; a press for key 5 is reported again 4 scans after restart.
